// File: rtl/fifo_pattern_writer.sv
// fifo_pattern_writer: writes a burst of patterned words into a FIFO,
// honouring full_in backpressure and an optional idle gap after each write.
module fifo_pattern_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [1:0]            mode,
    input  logic [3:0]            gap,
    input  logic                  full_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  enable_out,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  count,
    output logic [LEN_WIDTH-1:0]  stall_count
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                state, state_next;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [1:0]            mode_r;
    logic [3:0]            gap_r, gap_cnt;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  accept_start, last_word;

    assign accept_start = (state == IDLE) && start;
    assign enable_out   = (state == WRITE) && (gap_cnt == '0) && !full_in;
    assign last_word    = enable_out && (LEN_WIDTH'(count + 1'b1) == len_r);
    assign busy         = (state == WRITE);
    assign done         = (state == DONE);
    assign data_next    = mode_r == 2'b00 ? data_out + 1'b1 :
                          mode_r == 2'b01 ? data_out - 1'b1 :
                          mode_r == 2'b10 ? data_out :
                          {data_out[DATA_WIDTH-2:0], data_out[DATA_WIDTH-1]};

    always_ff @(posedge clk_in) begin
        state <= reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        if (accept_start)
            state_next = (length == '0) ? DONE : WRITE;
        else if (last_word)
            state_next = DONE;
        else if (state == DONE)
            state_next = IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            data_out    <= '0;
            count       <= '0;
            stall_count <= '0;
            gap_cnt     <= '0;
            len_r       <= '0;
            mode_r      <= '0;
            gap_r       <= '0;
        end else if (accept_start) begin
            data_out    <= seed;
            len_r       <= length;
            mode_r      <= mode;
            gap_r       <= gap;
            count       <= '0;
            stall_count <= '0;
            gap_cnt     <= '0;
        end else if (state == WRITE) begin
            if (enable_out) begin
                count    <= count + 1'b1;
                gap_cnt  <= gap_r;
                data_out <= data_next;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end else if (full_in && stall_count != '1) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_pattern_writer.sv
// tb_fifo_pattern_writer: directed bench for fifo_pattern_writer; "cycle k"
// is the clock period that follows rising edge k, where edge 0 accepts start.
module tb_fifo_pattern_writer;
    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  seed = '0;
    logic [15:0] length = '0;
    logic [1:0]  mode = '0;
    logic [3:0]  gap = '0;
    logic        full_in = 1'b0;
    logic [7:0]  data_out;
    logic        enable_out, busy, done;
    logic [15:0] count, stall_count;
    int          checks = 0;
    int          failures = 0;

    fifo_pattern_writer dut (
        .clk_in(clk_in), .reset(reset), .start(start), .seed(seed),
        .length(length), .mode(mode), .gap(gap), .full_in(full_in),
        .data_out(data_out), .enable_out(enable_out), .busy(busy),
        .done(done), .count(count), .stall_count(stall_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Settle combinational outputs for the current cycle's inputs, then check.
    task automatic word(input string tag, input logic en, input logic [7:0] d);
        #1;
        chk({tag, "_en"}, 32'(enable_out), 32'(en));
        if (en) chk({tag, "_data"}, 32'(data_out), 32'(d));
    endtask

    task automatic fin(input string tag, input logic [15:0] c, input logic [15:0] s);
        #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_en_at_done"}, 32'(enable_out), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_stall"}, 32'(stall_count), 32'(s));
        step();
        #1;
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_count_hold"}, 32'(count), 32'(c));
    endtask

    task automatic go(input logic [7:0] sd, input logic [15:0] ln, input logic [1:0] md, input logic [3:0] gp);
        seed = sd; length = ln; mode = md; gap = gp; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        step();
        step();
        #1;
        chk("rst_en", 32'(enable_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_stall", 32'(stall_count), 0);
        reset = 1'b0;
        step();

        go(8'h35, 16'd4, 2'b00, 4'd0);
        #1 chk("inc_busy", 32'(busy), 1);
        word("inc1", 1, 8'h35); step();
        word("inc2", 1, 8'h36); step();
        word("inc3", 1, 8'h37); step();
        word("inc4", 1, 8'h38); step();
        fin("inc", 16'd4, 16'd0);

        go(8'h35, 16'd4, 2'b00, 4'd0);
        word("stl1", 1, 8'h35); step();
        full_in = 1'b1;
        word("stl2", 0, 8'h36);
        chk("stl2_hold", 32'(data_out), 32'h36);
        step();
        full_in = 1'b0;
        start = 1'b1; seed = 8'hEE; mode = 2'b10;
        word("stl3", 1, 8'h36);
        chk("stl3_stall", 32'(stall_count), 1);
        step();
        start = 1'b0;
        word("stl4", 1, 8'h37); step();
        word("stl5", 1, 8'h38); step();
        fin("stl", 16'd4, 16'd1);

        go(8'hA5, 16'd3, 2'b10, 4'd2);
        word("gap1", 1, 8'hA5); step();
        full_in = 1'b1;
        word("gap2", 0, 8'hA5); step();
        full_in = 1'b0;
        word("gap3", 0, 8'hA5); step();
        word("gap4", 1, 8'hA5); step();
        word("gap5", 0, 8'hA5); step();
        word("gap6", 0, 8'hA5); step();
        word("gap7", 1, 8'hA5); step();
        fin("gap", 16'd3, 16'd0);

        go(8'h81, 16'd3, 2'b11, 4'd0);
        word("rot1", 1, 8'h81); step();
        word("rot2", 1, 8'h03); step();
        word("rot3", 1, 8'h06); step();
        fin("rot", 16'd3, 16'd0);

        go(8'h01, 16'd3, 2'b01, 4'd0);
        word("dec1", 1, 8'h01); step();
        word("dec2", 1, 8'h00); step();
        word("dec3", 1, 8'hFF); step();
        fin("dec", 16'd3, 16'd0);

        go(8'h55, 16'd0, 2'b00, 4'd0);
        #1 chk("len0_busy", 32'(busy), 0);
        word("len0", 0, 8'h00);
        fin("len0", 16'd0, 16'd0);

        go(8'h10, 16'd1, 2'b00, 4'd0);
        full_in = 1'b1;
        word("last_blk", 0, 8'h10);
        chk("last_blk_busy", 32'(busy), 1);
        step();
        full_in = 1'b0;
        word("last_ok", 1, 8'h10); step();
        fin("last", 16'd1, 16'd1);

        go(8'h35, 16'd4, 2'b00, 4'd0);
        word("abt1", 1, 8'h35); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("abt_busy", 32'(busy), 0);
        chk("abt_en", 32'(enable_out), 0);
        chk("abt_count", 32'(count), 0);
        chk("abt_data", 32'(data_out), 0);
        chk("abt_done", 32'(done), 0);
        step();
        #1;
        chk("abt_no_done", 32'(done), 0);
        chk("abt_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_pattern_writer.md
FIFO_PATTERN_WRITER -- requirements
Module: fifo_pattern_writer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of generated data and FIFO write port.
REQ-002 Parameter: LEN_WIDTH, 16, width of burst length, word count and stall count.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: clk_in  input  1  clock; all state updates on its rising edge.
REQ-005 Port: start  input  1  request a burst; sampled only in IDLE.
REQ-006 Port: seed  input  DATA_WIDTH  first data word of the burst; captured on start acceptance.
REQ-007 Port: length  input  LEN_WIDTH  words per burst; captured on start acceptance.
REQ-008 Port: mode  input  2  pattern: 00 increment, 01 decrement, 10 constant, 11 rotate-left-by-1; captured on start acceptance.
REQ-009 Port: gap  input  4  idle cycles forced after each accepted write; captured on start acceptance.
REQ-010 Port: full_in  input  1  FIFO full flag; write is blocked while high.
REQ-011 Port: data_out  output  DATA_WIDTH  FIFO write data.
REQ-012 Port: enable_out  output  1  FIFO write enable.
REQ-013 Port: busy  output  1  high in WRITE state.
REQ-014 Port: done  output  1  one-cycle pulse at burst completion.
REQ-015 Port: count  output  LEN_WIDTH  words accepted in current/last burst.
REQ-016 Port: stall_count  output  LEN_WIDTH  cycles blocked by full_in in current/last burst.

Function
REQ-017 States SHALL be IDLE, WRITE and DONE; busy = (state==WRITE), done = (state==DONE), both decoded from the state register.
REQ-018 In IDLE with start=1 the block SHALL capture seed/length/mode/gap, load data_out=seed, clear count, stall_count and gap counter, and go to WRITE, or to DONE if length==0.
REQ-019 start SHALL be ignored in WRITE and DONE; no queuing.
REQ-020 enable_out SHALL be combinational: (state==WRITE) && (gap counter==0) && !full_in.
REQ-021 A word is accepted on each rising edge with enable_out=1; on acceptance count increments, gap counter loads captured gap, and data_out advances per mode.
REQ-022 Data advance: 00 data+1 mod 2^DATA_WIDTH; 01 data-1 mod 2^DATA_WIDTH; 10 unchanged; 11 {data[DATA_WIDTH-2:0], data[DATA_WIDTH-1]}.
REQ-023 data_out SHALL hold its value on every non-accepting cycle, including stalls and gap cycles.
REQ-024 In WRITE, gap counter SHALL decrement by 1 on each cycle it is nonzero, independent of full_in.
REQ-025 In WRITE with gap counter==0 and full_in=1, stall_count SHALL increment, saturating at all-ones.
REQ-026 When the accepted word brings count to captured length, state SHALL go to DONE on that edge; no further enable_out.
REQ-027 DONE SHALL last exactly one cycle, then IDLE; count and stall_count SHALL hold until next start acceptance.
REQ-028 Latency: start accepted on edge N puts the first word on enable_out/data_out during cycle N+1 (if full_in=0).
REQ-029 full_in rising in the same cycle as the last word blocks it; completion waits for acceptance.

Reset
REQ-030 reset=1 at a rising edge SHALL force state IDLE, data_out=0, count=0, stall_count=0, gap counter=0, captured registers=0, regardless of state.
REQ-031 During and after reset, enable_out, busy and done SHALL be 0; reset mid-burst aborts without done.

Verification
REQ-032 seed=8'h35, length=4, mode=00, gap=0, full_in=0, start at edge 0 -> enable_out high cycles 1-4, data 35,36,37,38; done cycle 5; count=4, stall_count=0.
REQ-033 Same as REQ-032 with full_in=1 during cycle 2 only -> enable_out low cycle 2, data_out holds 36; writes 35,36,37,38 in cycles 1,3,4,5; done cycle 6; stall_count=1.
REQ-034 seed=8'hA5, length=3, mode=10, gap=2 -> writes of A5 in cycles 1,4,7 only; done cycle 8; count=3.
REQ-035 seed=8'h81, length=3, mode=11 -> data 81,03,06; mode=01, seed=8'h01, length=3 -> data 01,00,FF.
REQ-036 length=0 -> no enable_out, done cycle 1, count=0; start asserted while busy -> ignored, burst unchanged.
REQ-037 reset asserted cycle 2 of REQ-032 burst -> from next cycle state IDLE, enable_out=0, count=0, data_out=0, no done pulse.
